// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit layout and address field widths for the PWM register bank.
package pwm_pkg;
  localparam int CH_W = 4;

  localparam logic [3:0] OFF_PERIOD_L = 4'h0;
  localparam logic [3:0] OFF_PERIOD_H = 4'h1;
  localparam logic [3:0] OFF_CTRL     = 4'h2;
  localparam logic [3:0] OFF_CMP1_L   = 4'h3;
  localparam logic [3:0] OFF_CMP1_H   = 4'h4;
  localparam logic [3:0] OFF_CMP2_L   = 4'h5;
  localparam logic [3:0] OFF_CMP2_H   = 4'h6;
  localparam logic [3:0] OFF_CNT_RST  = 4'h7;
  localparam logic [3:0] OFF_CNT_L    = 4'h8;
  localparam logic [3:0] OFF_CNT_H    = 4'h9;
  localparam logic [3:0] OFF_PRESCALE = 4'hA;
  localparam logic [3:0] OFF_STATUS   = 4'hB;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_UPND  = 1;
  localparam int CTRL_PWMEN = 2;
  localparam int CTRL_FN_LO = 3;
  localparam int CTRL_FN_HI = 4;

  // Field order matches the CTRL byte, so {3'b0, ctrl} is the readback value.
  typedef struct packed {
    logic [1:0] fn;
    logic       pwm_en;
    logic       upnd;
    logic       en;
  } ctrl_t;

  function automatic logic off_valid(input logic [3:0] off);
    return off <= OFF_STATUS;
  endfunction
endpackage

// File: rtl/pwm_reg_chan.sv
// One PWM channel's register set. Double buffering of PERIOD/CMP1/CMP2
// is built only when PWM_REG_BANK_SHADOW_EN is defined.
module pwm_reg_chan
  import pwm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [3:0]  off_i,
  input  logic [7:0]  wdata_i,
  input  logic [15:0] cnt_i,
  input  logic        upd_i,
  output logic [7:0]  rdata_o,
  output logic [15:0] period_o,
  output logic [15:0] cmp1_o,
  output logic [15:0] cmp2_o,
  output logic [7:0]  presc_o,
  output ctrl_t       ctrl_o,
  output logic        crst_o
);
  logic [15:0] per_q, per_d, c1_q, c1_d, c2_q, c2_d;
  logic [15:0] per_prog, c1_prog, c2_prog;
  logic [7:0]  stg_q, stg_d, presc_q, presc_d, cnth_q, cnth_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        crst_q, crst_d, pend_q, pend_d;
  logic        wr_per, wr_c1, wr_c2;

  assign wr_per = wr_i && (off_i == OFF_PERIOD_H);
  assign wr_c1  = wr_i && (off_i == OFF_CMP1_H);
  assign wr_c2  = wr_i && (off_i == OFF_CMP2_H);

`ifdef PWM_REG_BANK_SHADOW_EN
  logic [15:0] per_sh_q, per_sh_d, c1_sh_q, c1_sh_d, c2_sh_q, c2_sh_d;

  // Transfer uses the old shadow; a same-cycle commit re-arms pending.
  always_comb begin
    per_sh_d = per_sh_q;
    c1_sh_d  = c1_sh_q;
    c2_sh_d  = c2_sh_q;
    per_d    = per_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    pend_d   = pend_q;
    if (upd_i || !ctrl_q.en) begin
      per_d  = per_sh_q;
      c1_d   = c1_sh_q;
      c2_d   = c2_sh_q;
      pend_d = 1'b0;
    end
    if (wr_per) per_sh_d = {wdata_i, stg_q};
    if (wr_c1)  c1_sh_d  = {wdata_i, stg_q};
    if (wr_c2)  c2_sh_d  = {wdata_i, stg_q};
    if (wr_per || wr_c1 || wr_c2) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_sh_q <= '0;
      c1_sh_q  <= '0;
      c2_sh_q  <= '0;
    end else begin
      per_sh_q <= per_sh_d;
      c1_sh_q  <= c1_sh_d;
      c2_sh_q  <= c2_sh_d;
    end
  end

  assign per_prog = per_sh_q;
  assign c1_prog  = c1_sh_q;
  assign c2_prog  = c2_sh_q;
`else
  logic unused_upd;
  assign unused_upd = upd_i;

  always_comb begin
    per_d = per_q;
    c1_d  = c1_q;
    c2_d  = c2_q;
    if (wr_per) per_d = {wdata_i, stg_q};
    if (wr_c1)  c1_d  = {wdata_i, stg_q};
    if (wr_c2)  c2_d  = {wdata_i, stg_q};
  end

  assign pend_d   = 1'b0;
  assign per_prog = per_q;
  assign c1_prog  = c1_q;
  assign c2_prog  = c2_q;
`endif

  always_comb begin
    stg_d   = stg_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cnth_d  = cnth_q;
    crst_d  = 1'b0;
    if (wr_i) begin
      case (off_i)
        OFF_PERIOD_L, OFF_CMP1_L, OFF_CMP2_L: stg_d = wdata_i;
        OFF_CTRL: begin
          ctrl_d.en     = wdata_i[CTRL_EN];
          ctrl_d.upnd   = wdata_i[CTRL_UPND];
          ctrl_d.pwm_en = wdata_i[CTRL_PWMEN];
          ctrl_d.fn     = wdata_i[CTRL_FN_HI:CTRL_FN_LO];
        end
        OFF_PRESCALE: presc_d = wdata_i;
        OFF_CNT_RST:  crst_d  = wdata_i[0];
        default: ;
      endcase
    end
    // Snapshot the high byte so a following CNT_H read is coherent with CNT_L.
    if (rd_i && (off_i == OFF_CNT_L)) cnth_d = cnt_i[15:8];
  end

  always_comb begin
    rdata_o = 8'h00;
    case (off_i)
      OFF_PERIOD_L: rdata_o = per_prog[7:0];
      OFF_PERIOD_H: rdata_o = per_prog[15:8];
      OFF_CTRL:     rdata_o = {3'b000, ctrl_q};
      OFF_CMP1_L:   rdata_o = c1_prog[7:0];
      OFF_CMP1_H:   rdata_o = c1_prog[15:8];
      OFF_CMP2_L:   rdata_o = c2_prog[7:0];
      OFF_CMP2_H:   rdata_o = c2_prog[15:8];
      OFF_CNT_L:    rdata_o = cnt_i[7:0];
      OFF_CNT_H:    rdata_o = cnth_q;
      OFF_PRESCALE: rdata_o = presc_q;
      OFF_STATUS:   rdata_o = {7'b0, pend_q};
      default:      rdata_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      stg_q   <= '0;
      presc_q <= '0;
      cnth_q  <= '0;
      ctrl_q  <= '0;
      crst_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      per_q   <= per_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      stg_q   <= stg_d;
      presc_q <= presc_d;
      cnth_q  <= cnth_d;
      ctrl_q  <= ctrl_d;
      crst_q  <= crst_d;
      pend_q  <= pend_d;
    end
  end

  assign period_o = per_q;
  assign cmp1_o   = c1_q;
  assign cmp2_o   = c2_q;
  assign presc_o  = presc_q;
  assign ctrl_o   = ctrl_q;
  assign crst_o   = crst_q;
endmodule

// File: rtl/pwm_reg_bank.sv
// Byte-wide register bank for N_CH PWM channels: address decode and registered read mux.
// Optional double buffering: PWM_REG_BANK_SHADOW_EN.
module pwm_reg_bank
  import pwm_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                write,
  input  logic [7:0]          addr,
  input  logic [7:0]          data_write,
  output logic [7:0]          data_read,
  input  logic [16*N_CH-1:0]  counter_val,
  input  logic [N_CH-1:0]     update_evt,
  output logic [16*N_CH-1:0]  period,
  output logic [16*N_CH-1:0]  compare1,
  output logic [16*N_CH-1:0]  compare2,
  output logic [8*N_CH-1:0]   prescale,
  output logic [N_CH-1:0]     en,
  output logic [N_CH-1:0]     upnotdown,
  output logic [N_CH-1:0]     pwm_en,
  output logic [N_CH-1:0]     count_reset,
  output logic [2*N_CH-1:0]   functions
);
  logic [CH_W-1:0]        ch;
  logic [3:0]             off;
  logic [N_CH-1:0]        sel;
  logic [N_CH-1:0][7:0]   rdata;
  logic [7:0]             data_read_q, data_read_d;

  assign ch  = addr[7:4];
  assign off = addr[3:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ctrl_t ctrl;
    assign sel[i] = (ch == CH_W'(i)) && off_valid(off);

    pwm_reg_chan u_chan (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_i    (write && sel[i]),
      .rd_i    (read && sel[i]),
      .off_i   (off),
      .wdata_i (data_write),
      .cnt_i   (counter_val[16*i +: 16]),
      .upd_i   (update_evt[i]),
      .rdata_o (rdata[i]),
      .period_o(period[16*i +: 16]),
      .cmp1_o  (compare1[16*i +: 16]),
      .cmp2_o  (compare2[16*i +: 16]),
      .presc_o (prescale[8*i +: 8]),
      .ctrl_o  (ctrl),
      .crst_o  (count_reset[i])
    );

    assign en[i]               = ctrl.en;
    assign upnotdown[i]        = ctrl.upnd;
    assign pwm_en[i]           = ctrl.pwm_en;
    assign functions[2*i +: 2] = ctrl.fn;
  end

  // Out-of-range channel or offset leaves sel all-zero, so the read returns 0x00.
  always_comb begin
    data_read_d = 8'h00;
    if (read) begin
      for (int i = 0; i < N_CH; i++)
        if (sel[i]) data_read_d = data_read_d | rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_read_q <= 8'h00;
    else     data_read_q <= data_read_d;
  end

  assign data_read = data_read_q;
endmodule

// File: tb/tb_pwm_reg_bank.sv
// Self-checking bench for pwm_reg_bank: directed register-map scenarios plus random traffic
// against a register-level reference model (shadow mode follows PWM_REG_BANK_SHADOW_EN).
module tb_pwm_reg_bank;
  localparam int NCH = 4;
`ifdef PWM_REG_BANK_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, read, write;
  logic [7:0] addr, data_write, data_read;
  logic [NCH-1:0][15:0] cvp, period_w, cmp1_w, cmp2_w;
  logic [NCH-1:0][7:0]  presc_w;
  logic [NCH-1:0][1:0]  fn_w;
  logic [NCH-1:0] update_evt, en_w, upnd_w, pwmen_w, crst_w;

  pwm_reg_bank #(.N_CH(NCH)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(cvp),
    .update_evt(update_evt), .period(period_w), .compare1(cmp1_w),
    .compare2(cmp2_w), .prescale(presc_w), .en(en_w), .upnotdown(upnd_w),
    .pwm_en(pwmen_w), .count_reset(crst_w), .functions(fn_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: k = 0 PERIOD, 1 CMP1, 2 CMP2
  logic [15:0] m_prog [NCH][3];
  logic [15:0] m_act  [NCH][3];
  logic [15:0] prog_old [NCH][3];
  logic [7:0]  m_stg [NCH], m_ctrl [NCH], m_presc [NCH], m_cnth [NCH];
  logic        m_pend [NCH];
  logic [NCH-1:0] m_crst;
  logic [7:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 3; k++) begin m_prog[c][k] = '0; m_act[c][k] = '0; end
      m_stg[c] = '0; m_ctrl[c] = '0; m_presc[c] = '0; m_cnth[c] = '0; m_pend[c] = 1'b0;
    end
    m_crst = '0;
    m_rd   = '0;
  endtask

  function automatic logic [7:0] model_read(input int c, input int o);
    case (o)
      0:  return m_prog[c][0][7:0];
      1:  return m_prog[c][0][15:8];
      2:  return m_ctrl[c];
      3:  return m_prog[c][1][7:0];
      4:  return m_prog[c][1][15:8];
      5:  return m_prog[c][2][7:0];
      6:  return m_prog[c][2][15:8];
      8:  return cvp[c][7:0];
      9:  return m_cnth[c];
      10: return m_presc[c];
      11: return {7'b0, m_pend[c]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input logic [NCH-1:0] u);
    int c, o, k;
    bit v;
    c = int'(a[7:4]);
    o = int'(a[3:0]);
    v = (c < NCH) && (o < 12);
    m_rd = (r && v) ? model_read(c, o) : 8'h00;
    prog_old = m_prog;
    m_crst = '0;
    if (SH)
      for (int ch = 0; ch < NCH; ch++)
        if (u[ch] || !m_ctrl[ch][0]) begin
          for (int j = 0; j < 3; j++) m_act[ch][j] = prog_old[ch][j];
          m_pend[ch] = 1'b0;
        end
    if (r && v && o == 8) m_cnth[c] = cvp[c][15:8];
    if (w && v) begin
      case (o)
        0, 3, 5: m_stg[c] = d;
        1, 4, 6: begin
          k = (o == 1) ? 0 : (o == 4) ? 1 : 2;
          m_prog[c][k] = {d, m_stg[c]};
          if (SH) m_pend[c] = 1'b1;
          else    m_act[c][k] = m_prog[c][k];
        end
        2:  m_ctrl[c] = d & 8'h1F;
        7:  m_crst[c] = d[0];
        10: m_presc[c] = d;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("data_read", 32'(data_read), 32'(m_rd));
    chk("count_reset", 32'(crst_w), 32'(m_crst));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("period%0d", c),   32'(period_w[c]), 32'(m_act[c][0]));
      chk($sformatf("compare1_%0d", c), 32'(cmp1_w[c]),  32'(m_act[c][1]));
      chk($sformatf("compare2_%0d", c), 32'(cmp2_w[c]),  32'(m_act[c][2]));
      chk($sformatf("prescale%0d", c), 32'(presc_w[c]),  32'(m_presc[c]));
      chk($sformatf("ctrl%0d", c),
          32'({fn_w[c], pwmen_w[c], upnd_w[c], en_w[c]}), 32'(m_ctrl[c][4:0]));
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [7:0] a,
                     input logic [7:0] d, input logic [NCH-1:0] u);
    read = r; write = w; addr = a; data_write = d; update_evt = u;
    model_edge(r, w, a, d, u);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; update_evt = '0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; read = 1'b0; write = 1'b0; update_evt = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_write = '0;
    update_evt = '0; cvp = '0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_period0", 32'(period_w[0]), 32'h0);
    chk("rst_count_reset", 32'(crst_w), 32'h0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, '0);
    chk("rst_read_period_l", 32'(data_read), 32'h00);

    // Shadow update on ch1
    cyc(1'b0, 1'b1, 8'h12, 8'h01, '0);
    cyc(1'b0, 1'b1, 8'h10, 8'h34, '0);
    chk("l_write_no_change", 32'(period_w[1]), 32'h0);
    cyc(1'b0, 1'b1, 8'h11, 8'h12, '0);
    chk("h_commit_period1", 32'(period_w[1]), SH ? 32'h0 : 32'h1234);
    cyc(1'b1, 1'b0, 8'h1B, 8'h00, '0);
    chk("status_pending", 32'(data_read), SH ? 32'h01 : 32'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 4'b0010);
    chk("update_period1", 32'(period_w[1]), 32'h1234);
    cyc(1'b1, 1'b0, 8'h1B, 8'h00, '0);
    chk("status_cleared", 32'(data_read), 32'h00);
    cyc(1'b1, 1'b0, 8'h11, 8'h00, '0);
    chk("read_period_h", 32'(data_read), 32'h12);

    // Commit coinciding with update_evt on ch0 CMP1
    cyc(1'b0, 1'b1, 8'h02, 8'h01, '0);
    cyc(1'b0, 1'b1, 8'h03, 8'h55, '0);
    cyc(1'b0, 1'b1, 8'h04, 8'h00, '0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 4'b0001);
    chk("cmp1_prior", 32'(cmp1_w[0]), 32'h0055);
    cyc(1'b0, 1'b1, 8'h03, 8'hAA, '0);
    cyc(1'b0, 1'b1, 8'h04, 8'h00, 4'b0001);
    chk("coinc_active", 32'(cmp1_w[0]), SH ? 32'h0055 : 32'h00AA);
    cyc(1'b1, 1'b0, 8'h0B, 8'h00, '0);
    chk("coinc_pending", 32'(data_read), SH ? 32'h01 : 32'h00);
    cyc(1'b1, 1'b0, 8'h03, 8'h00, '0);
    chk("read_shadow_cmp1", 32'(data_read), 32'hAA);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 4'b0001);
    chk("coinc_next_update", 32'(cmp1_w[0]), 32'h00AA);

    // Counter snapshot on ch2
    cvp[2] = 16'h12FF;
    cyc(1'b1, 1'b0, 8'h28, 8'h00, '0);
    chk("cnt_l", 32'(data_read), 32'hFF);
    cvp[2] = 16'h1300;
    cyc(1'b1, 1'b0, 8'h29, 8'h00, '0);
    chk("cnt_h_latched", 32'(data_read), 32'h12);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, '0);
    chk("no_read_zero", 32'(data_read), 32'h00);

    // Count reset pulses on ch3
    cyc(1'b0, 1'b1, 8'h37, 8'h01, '0);
    chk("crst_pulse", 32'(crst_w[3]), 32'h1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, '0);
    chk("crst_one_cycle", 32'(crst_w[3]), 32'h0);
    cyc(1'b0, 1'b1, 8'h37, 8'h01, '0);
    cyc(1'b0, 1'b1, 8'h37, 8'h01, '0);
    chk("crst_back_to_back", 32'(crst_w[3]), 32'h1);
    cyc(1'b0, 1'b1, 8'h37, 8'h00, '0);
    chk("crst_bit0_clear", 32'(crst_w[3]), 32'h0);
    cyc(1'b1, 1'b0, 8'h37, 8'h00, '0);
    chk("crst_reads_zero", 32'(data_read), 32'h00);

    // Out-of-range channel and offset
    cyc(1'b0, 1'b1, 8'h5F, 8'hFF, '0);
    cyc(1'b1, 1'b0, 8'h5F, 8'h00, '0);
    chk("range_5f", 32'(data_read), 32'h00);
    cyc(1'b0, 1'b1, 8'h4A, 8'hEE, '0);
    cyc(1'b0, 1'b1, 8'h0C, 8'hEE, '0);
    cyc(1'b1, 1'b0, 8'h0C, 8'h00, '0);
    chk("range_off_c", 32'(data_read), 32'h00);

    // Same-cycle read and write of one address
    cyc(1'b0, 1'b1, 8'h0A, 8'h11, '0);
    cyc(1'b1, 1'b1, 8'h0A, 8'h22, '0);
    chk("rw_same_old", 32'(data_read), 32'h11);
    cyc(1'b1, 1'b0, 8'h0A, 8'h00, '0);
    chk("rw_same_new", 32'(data_read), 32'h22);

    // Reset between _L and _H discards the staged byte
    cyc(1'b0, 1'b1, 8'h20, 8'h77, '0);
    do_reset();
    cyc(1'b0, 1'b1, 8'h21, 8'h05, '0);
    cyc(1'b1, 1'b0, 8'h20, 8'h00, '0);
    chk("midrst_low", 32'(data_read), 32'h00);
    cyc(1'b1, 1'b0, 8'h21, 8'h00, '0);
    chk("midrst_high", 32'(data_read), 32'h05);
    chk("midrst_period2", 32'(period_w[2]), 32'h0500);

    // Direct commit with en=1 and no update_evt
    cyc(1'b0, 1'b1, 8'h32, 8'h01, '0);
    cyc(1'b0, 1'b1, 8'h30, 8'h10, '0);
    cyc(1'b0, 1'b1, 8'h31, 8'h00, '0);
    chk("direct_period3", 32'(period_w[3]), SH ? 32'h0000 : 32'h0010);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ra, rd_;
      logic rr, rw;
      logic [NCH-1:0] ru;
      ra  = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      rd_ = 8'($urandom);
      rr  = 1'($urandom);
      rw  = 1'($urandom);
      ru  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) cvp[$urandom_range(0, NCH-1)] = 16'($urandom);
      cyc(rr, rw, ra, rd_, ru);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_reg_bank.md
PWM_REG_BANK -- requirements
Module: pwm_reg_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of PWM channels (1..16).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  reset; no other clock or reset.
REQ-003 SHALL have port read  in  1  byte read strobe.
REQ-004 SHALL have port write  in  1  byte write strobe.
REQ-005 SHALL have port addr  in  8  address: addr[7:4] is the channel, addr[3:0] is the register offset.
REQ-006 SHALL have port data_write  in  8  write data.
REQ-007 SHALL have port data_read  out  8  registered read data.
REQ-008 SHALL have port counter_val  in  16*N_CH  live counter value per channel.
REQ-009 SHALL have port update_evt  in  N_CH  per-channel period-boundary pulse from the counter.
REQ-010 SHALL have ports period, compare1 and compare2  out  16*N_CH  active values.
REQ-011 SHALL have port prescale  out  8*N_CH.
REQ-012 SHALL have ports en, upnotdown, pwm_en and count_reset  out  N_CH each.
REQ-013 SHALL have port functions  out  2*N_CH.

Function
REQ-014 SHALL use this per-channel offset map:
- 0x0 PERIOD_L, 0x1 PERIOD_H
- 0x2 CTRL: bit0 en, bit1 upnotdown, bit2 pwm_en, bits4:3 functions
- 0x3 CMP1_L, 0x4 CMP1_H, 0x5 CMP2_L, 0x6 CMP2_H
- 0x7 CNT_RST: write-only, reads 0
- 0x8 CNT_L, 0x9 CNT_H: read-only
- 0xA PRESCALE
- 0xB STATUS: read-only; bit0 pending
REQ-015 SHALL make a write to any _L offset load a per-channel staging byte only, with no visible output change.
REQ-016 SHALL make a write to an _H offset commit {data_write, staging byte} into that register's shadow in one cycle and set pending.
REQ-017 SHALL copy all three shadows to the active outputs on the cycle after update_evt[ch]=1, and clear pending.
REQ-018 SHALL copy shadows to active on the cycle after a commit whenever en[ch]=0.
REQ-019 SHALL, when a commit and update_evt coincide, transfer the old shadow, store the new value in the shadow, and leave pending=1.
REQ-020 SHALL apply writes to CTRL and PRESCALE directly to the outputs on the next edge.
REQ-021 SHALL make a write to CNT_RST with data_write[0]=1 drive count_reset[ch] high for exactly one cycle; back-to-back writes SHALL give back-to-back pulses.
REQ-022 SHALL make a read of CNT_L return counter_val[ch][7:0] and latch [15:8] in the same cycle; a read of CNT_H SHALL return the latched byte.
REQ-023 SHALL make data_read valid the cycle after read=1 and 0x00 in any cycle not following a read.
REQ-024 SHALL return the pre-write value when read and write target the same address in the same cycle.
REQ-025 SHALL ignore writes to, and return 0x00 on reads of, channel >= N_CH or offsets 0xC..0xF.
REQ-026 SHALL make reads of PERIOD, CMP1 and CMP2 return the shadow (programmed) value, not the active value.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, clear all active, shadow, staging, latch and pending state and data_read to zero.
REQ-028 SHALL, on reset asserted mid-sequence (after _L, before _H), discard the staged byte; a later _H write SHALL commit with a low byte of 0x00.

Configuration
REQ-029 SHALL, with macro PWM_REG_BANK_SHADOW_EN defined, implement the double buffering of REQ-016..REQ-019.
REQ-030 SHALL, without PWM_REG_BANK_SHADOW_EN, make an _H commit write the active register directly on the next edge, ignore update_evt, and hold STATUS.pending at 0.

Structure
REQ-031 SHALL place offset constants, CTRL bit positions and the channel-field width in shared package pwm_pkg.
REQ-032 SHALL implement one channel's register set as sub-module pwm_reg_chan, instantiated N_CH times; the top SHALL decode addr and mux read data.

Verification
REQ-033 Reset: rst=1 for 2 cycles -> all outputs 0, read of ch0 PERIOD_L returns 0x00.
REQ-034 Shadow update: ch1 en=1; write PERIOD_L=0x34, PERIOD_H=0x12 -> period[ch1] unchanged, STATUS=0x01; pulse update_evt[1] -> period[ch1]=0x1234 next cycle, STATUS=0x00.
REQ-035 Coincidence: commit CMP1 0x00AA on the same cycle as update_evt[0], with the prior shadow at 0x0055 -> active=0x0055, pending=1; next update_evt -> active=0x00AA.
REQ-036 Counter snapshot: counter_val[ch2]=0x12FF; read CNT_L; counter changes to 0x1300; read CNT_H -> reads return 0xFF, then 0x12.
REQ-037 Pulse and range: write CNT_RST=0x01 to ch3 -> count_reset[3] high exactly 1 cycle; write addr 0x5F with N_CH=4 -> no state change, read returns 0x00.
REQ-038 Macro off: write PERIOD_L=0x10, PERIOD_H=0x00 with en=1 -> period=0x0010 next cycle with no update_evt.
